mem_bus_if: RTL and testbench

- CPU-side bus interface unit between the multi-cycle datapath and the external word-addressed memory bus (readM/writeM/address/data/inputReady/ackOutput).
- Accepts instruction-fetch and load/store requests from the control unit and arbitrates them onto the single bus.
- Runs the bus handshake, captures read data, and returns one response per request.
- Flags bus timeouts so the CPU never hangs on a dead memory.

---
 rtl/cpu_defs_pkg.sv | 20 ++
 rtl/bus_timeout_ctr.sv | 33 +++
 rtl/mem_bus_if.sv | 211 +++++++++++++++++++++
 tb/tb_mem_bus_if.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: word width, bus FSM encoding and request tags.
package cpu_defs_pkg;

  localparam int WORD_SIZE = 16;

  // Width of the bus timeout counter; TIMEOUT may range 1..255.
  localparam int CTR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } bus_state_t;

  // Which requester owns the transfer in flight.
  localparam logic TAG_FETCH = 1'b0;
  localparam logic TAG_DATA  = 1'b1;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Loadable saturating up-counter used to bound how long a bus strobe waits
// for the memory to answer. o_expired is high once the count reaches i_limit.
module bus_timeout_ctr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  // Count register: clear wins over load, load wins over increment; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count >= i_limit);

endmodule

// File: rtl/mem_bus_if.sv
// CPU bus interface unit: arbitrates fetch and load/store requests onto the
// single word-addressed memory bus, runs the readM/writeM handshake, returns
// one response per request and aborts transfers the memory never answers.
module mem_bus_if #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_req,
  input  logic [WORD_SIZE-1:0] fetch_addr,
  output logic                 fetch_ready,
  output logic                 fetch_valid,
  output logic [WORD_SIZE-1:0] fetch_data,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [WORD_SIZE-1:0] data_addr,
  input  logic [WORD_SIZE-1:0] data_wdata,
  output logic                 data_ready,
  output logic                 data_valid,
  output logic [WORD_SIZE-1:0] data_rdata,
  output logic                 bus_err,
  output logic                 busy,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput
);

  import cpu_defs_pkg::*;

  // The strobe is dropped on the edge where the count has reached TIMEOUT-1,
  // so it stays high for exactly TIMEOUT clocks.
  localparam logic [CTR_W-1:0] TO_LIMIT = CTR_W'(TIMEOUT - 1);

  bus_state_t           r_state;
  bus_state_t           w_state_next;
  logic                 r_tag;
  logic                 w_tag_next;
  logic                 r_readM;
  logic                 w_readM_next;
  logic                 r_writeM;
  logic                 w_writeM_next;
  logic                 r_fetch_valid;
  logic                 w_fetch_valid_next;
  logic                 r_data_valid;
  logic                 w_data_valid_next;
  logic                 r_bus_err;
  logic                 w_bus_err_next;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_fetch_data;
  logic [WORD_SIZE-1:0] r_data_rdata;
  logic                 w_cap_fetch;
  logic                 w_cap_data;
  logic [WORD_SIZE-1:0] w_cap_val;
  logic                 w_fetch_ready;
  logic                 w_data_ready;
  logic                 w_accept;
  logic                 w_ctr_en;
  logic                 w_expired;

  bus_timeout_ctr #(
    .WIDTH (CTR_W)
  ) u_timeout (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_accept),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_ctr_en),
    .i_limit    (TO_LIMIT),
    .o_expired  (w_expired)
  );

  // Next-state and next-output decode for the bus FSM.
  always_comb begin
    w_state_next       = r_state;
    w_tag_next         = r_tag;
    w_readM_next       = r_readM;
    w_writeM_next      = r_writeM;
    w_fetch_valid_next = 1'b0;
    w_data_valid_next  = 1'b0;
    w_bus_err_next     = 1'b0;
    w_cap_fetch        = 1'b0;
    w_cap_data         = 1'b0;
    w_cap_val          = data;
    w_fetch_ready      = 1'b0;
    w_data_ready       = 1'b0;
    w_ctr_en           = 1'b0;
    case (r_state)
      IDLE: begin
        // Load/store outranks fetch; nothing is accepted while reset is held.
        w_data_ready  = reset_n & data_req;
        w_fetch_ready = reset_n & fetch_req & ~data_req;
        if (w_data_ready) begin
          w_tag_next = TAG_DATA;
          if (data_we) begin
            w_state_next  = WRITE;
            w_writeM_next = 1'b1;
          end else begin
            w_state_next = READ;
            w_readM_next = 1'b1;
          end
        end else if (w_fetch_ready) begin
          w_tag_next   = TAG_FETCH;
          w_state_next = READ;
          w_readM_next = 1'b1;
        end
      end
      READ: begin
        w_ctr_en = 1'b1;
        // A real ack wins over a coincident timeout.
        if (inputReady || w_expired) begin
          w_readM_next   = 1'b0;
          w_state_next   = RELEASE;
          w_bus_err_next = ~inputReady;
          w_cap_val      = inputReady ? data : '0;
          if (r_tag == TAG_FETCH) begin
            w_cap_fetch        = 1'b1;
            w_fetch_valid_next = 1'b1;
          end else begin
            w_cap_data        = 1'b1;
            w_data_valid_next = 1'b1;
          end
        end
      end
      WRITE: begin
        w_ctr_en = 1'b1;
        if (ackOutput || w_expired) begin
          w_writeM_next     = 1'b0;
          w_state_next      = RELEASE;
          w_bus_err_next    = ~ackOutput;
          w_data_valid_next = 1'b1;
        end
      end
      RELEASE: begin
        // Let the memory drop its level handshake before starting anything new.
        if (!inputReady && !ackOutput) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_accept = w_fetch_ready | w_data_ready;

  // FSM state and registered strobes/response pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_tag         <= TAG_FETCH;
      r_readM       <= 1'b0;
      r_writeM      <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      r_bus_err     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_tag         <= w_tag_next;
      r_readM       <= w_readM_next;
      r_writeM      <= w_writeM_next;
      r_fetch_valid <= w_fetch_valid_next;
      r_data_valid  <= w_data_valid_next;
      r_bus_err     <= w_bus_err_next;
    end
  end

  // Request latching on accept and read-data capture on completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_fetch_data <= '0;
      r_data_rdata <= '0;
    end else begin
      if (w_data_ready) begin
        r_addr  <= data_addr;
        r_wdata <= data_wdata;
      end else if (w_fetch_ready) begin
        r_addr <= fetch_addr;
      end
      if (w_cap_fetch) begin
        r_fetch_data <= w_cap_val;
      end
      if (w_cap_data) begin
        r_data_rdata <= w_cap_val;
      end
    end
  end

  // The CPU only drives the shared bus during a write strobe.
  assign data        = r_writeM ? r_wdata : 'z;
  assign readM       = r_readM;
  assign writeM      = r_writeM;
  assign address     = r_addr;
  assign fetch_ready = w_fetch_ready;
  assign data_ready  = w_data_ready;
  assign fetch_valid = r_fetch_valid;
  assign data_valid  = r_data_valid;
  assign fetch_data  = r_fetch_data;
  assign data_rdata  = r_data_rdata;
  assign bus_err     = r_bus_err;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_if.sv
// Scenario bench for mem_bus_if with a behavioural word memory on the bus.
`timescale 1ns/1ps
module tb_mem_bus_if;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0;
  logic        fetch_ready, fetch_valid;
  logic [15:0] fetch_data;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [15:0] data_addr = 16'h0;
  logic [15:0] data_wdata = 16'h0;
  logic        data_ready, data_valid;
  logic [15:0] data_rdata;
  logic        bus_err, busy, readM, writeM;
  logic [15:0] address;
  wire  [15:0] data;
  logic        inputReady = 1'b0;
  logic        ackOutput = 1'b0;

  // memory model controls
  logic [15:0] mem [0:255];
  int          rd_lat = 1;
  int          wr_lat = 1;
  int          hold_extra = 0;
  bit          mem_dead = 1'b0;
  bit          spur_ack = 1'b0;
  int          lat_cnt = 0;
  int          hold_cnt = 0;
  logic        mem_oe = 1'b0;
  logic [15:0] mem_drv = 16'h0;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_drv = 16'h0;

  typedef struct packed {
    logic        tag;
    logic        store;
    logic        err;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_rdata_hold = 16'h0;
  int          vec_cnt = 0;
  int          miss_cnt = 0;

  assign data = mem_oe ? mem_drv : (tb_oe ? tb_drv : 16'hzzzz);

  always #5 clk = ~clk;

  mem_bus_if #(.WORD_SIZE(16), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_valid(data_valid), .data_rdata(data_rdata),
    .bus_err(bus_err), .busy(busy), .readM(readM), .writeM(writeM),
    .address(address), .data(data), .inputReady(inputReady), .ackOutput(ackOutput)
  );

  // Memory responder: updates on the falling edge, stable at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        inputReady = 1'b0; ackOutput = 1'b0; mem_oe = 1'b0; lat_cnt = 0; hold_cnt = 0;
      end else if (readM && !mem_dead) begin
        if (lat_cnt >= rd_lat) begin
          inputReady = 1'b1; mem_oe = 1'b1; mem_drv = mem[address[7:0]];
        end else lat_cnt++;
      end else if (writeM && !mem_dead) begin
        if (lat_cnt >= wr_lat) begin
          if (!ackOutput) mem[address[7:0]] = data;
          ackOutput = 1'b1;
        end else lat_cnt++;
      end else begin
        mem_oe = 1'b0; lat_cnt = 0;
        if (spur_ack) ackOutput = 1'b1;
        else if ((inputReady || ackOutput) && hold_cnt < hold_extra) hold_cnt++;
        else begin inputReady = 1'b0; ackOutput = 1'b0; hold_cnt = 0; end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before 300us");
    $fatal(1);
  end

  // Drive one request from a falling edge until accepted; pushes the expected response.
  task automatic issue(input bit is_data, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_val,
                       input bit exp_err, output bit ok);
    exp_t e;
    ok = 1'b0;
    if (is_data) begin data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata; end
    else begin fetch_req = 1'b1; fetch_addr = addr; end
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (is_data ? data_ready : fetch_ready) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    data_req = 1'b0; fetch_req = 1'b0;
    data_addr = 16'hDEAD; fetch_addr = 16'hDEAD; data_wdata = 16'hDEAD; data_we = ~we;
    if (ok) begin
      e.tag = is_data; e.store = is_data & we; e.err = exp_err; e.val = exp_val;
      exp_q.push_back(e);
    end
  endtask

  // Observe from the falling edge after accept until a response pulse appears.
  task automatic wait_valid(input int max, input logic [15:0] exp_addr, output bit ok,
                            output int lat, output int strobe_cyc, output int addr_bad,
                            output int both, output logic [15:0] bus_seen);
    ok = 1'b0; lat = 0; strobe_cyc = 0; addr_bad = 0; both = 0; bus_seen = 16'h0;
    while (!ok && lat <= max) begin
      if (readM || writeM) begin
        strobe_cyc++;
        if (address !== exp_addr) addr_bad++;
      end
      if (readM && writeM) both++;
      if (writeM) bus_seen = data;
      if (fetch_valid || data_valid) ok = 1'b1;
      else begin @(negedge clk); lat++; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    fetch_req = 1'b1; data_req = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({readM, writeM, busy, fetch_ready, data_ready, fetch_valid, data_valid, bus_err} !== 8'h00) begin
      miss_cnt++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {readM, writeM, busy, fetch_ready, data_ready, fetch_valid, data_valid, bus_err});
    end
    vec_cnt++;
    if ({address, fetch_data, data_rdata} !== 48'h0) begin
      miss_cnt++;
      $display("FAIL reset_regs: got %h, required 0", {address, fetch_data, data_rdata});
    end
    tb_oe = 1'b1; tb_drv = 16'hA5C3; #1;
    vec_cnt++;
    if (data !== 16'hA5C3) begin
      miss_cnt++; $display("FAIL reset_bus_float: got %h, required a5c3", data);
    end
    tb_oe = 1'b0;
    fetch_req = 1'b0; data_req = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    $display("reset: checked control, registers and bus release");
  endtask

  task automatic test_fetch();
    bit ok; int lat, sc, ab, both; logic [15:0] bs; exp_t e;
    rd_lat = 1; mem[8'h04] = 16'hF300;
    issue(1'b0, 1'b0, 16'h0004, 16'h0, 16'hF300, 1'b0, ok);
    vec_cnt++;
    if (!ok) begin miss_cnt++; $display("FAIL fetch_accept: got ready=0, required 1"); end
    vec_cnt++;
    if ({readM, busy} !== 2'b11) begin miss_cnt++; $display("FAIL fetch_strobe: got %b, required 11", {readM, busy}); end
    wait_valid(40, 16'h0004, ok, lat, sc, ab, both, bs);
    vec_cnt++;
    if (!ok || exp_q.size() == 0) begin miss_cnt++; $display("FAIL fetch_resp: no response, required one"); end
    else begin
      e = exp_q.pop_front();
      if ({fetch_valid, data_valid, bus_err, fetch_data, readM} !== {~e.tag, e.tag, e.err, e.val, 1'b0}) begin
        miss_cnt++;
        $display("FAIL fetch_resp: got %h, required %h", {fetch_valid, data_valid, bus_err, fetch_data, readM},
                 {~e.tag, e.tag, e.err, e.val, 1'b0});
      end
    end
    vec_cnt++;
    if (lat != 2 || ab != 0) begin miss_cnt++; $display("FAIL fetch_timing: got lat=%0d addr_bad=%0d, required lat=2 addr_bad=0", lat, ab); end
    @(negedge clk);
    vec_cnt++;
    if ({fetch_valid, data_valid} !== 2'b00) begin miss_cnt++; $display("FAIL fetch_pulse: got %b, required 00", {fetch_valid, data_valid}); end
    wait_idle(ok);
    vec_cnt++;
    if (!ok) begin miss_cnt++; $display("FAIL fetch_idle: got busy=1, required 0"); end
    $display("fetch: addr 0004 data %h lat %0d", fetch_data, lat);
  endtask

  task automatic test_store_load();
    bit ok; int lat, sc, ab, both; logic [15:0] bs; exp_t e;
    wr_lat = 1; mem[8'h20] = 16'h0;
    issue(1'b1, 1'b1, 16'h0020, 16'h000A, exp_rdata_hold, 1'b0, ok);
    wait_valid(40, 16'h0020, ok, lat, sc, ab, both, bs);
    vec_cnt++;
    if (!ok || exp_q.size() == 0) begin miss_cnt++; $display("FAIL store_resp: no response, required one"); end
    else begin
      e = exp_q.pop_front();
      if ({fetch_valid, data_valid, bus_err, data_rdata} !== {~e.tag, e.tag, e.err, e.val}) begin
        miss_cnt++;
        $display("FAIL store_resp: got %h, required %h", {fetch_valid, data_valid, bus_err, data_rdata}, {~e.tag, e.tag, e.err, e.val});
      end
    end
    vec_cnt++;
    if (bs !== 16'h000A || both != 0 || ab != 0) begin
      miss_cnt++; $display("FAIL store_bus: got data=%h both=%0d addr_bad=%0d, required 000a 0 0", bs, both, ab);
    end
    wait_idle(ok);
    issue(1'b1, 1'b0, 16'h0020, 16'h0, 16'h000A, 1'b0, ok);
    wait_valid(40, 16'h0020, ok, lat, sc, ab, both, bs);
    vec_cnt++;
    if (!ok || exp_q.size() == 0) begin miss_cnt++; $display("FAIL load_resp: no response, required one"); end
    else begin
      e = exp_q.pop_front();
      if ({fetch_valid, data_valid, bus_err, data_rdata} !== {~e.tag, e.tag, e.err, e.val}) begin
        miss_cnt++;
        $display("FAIL load_resp: got %h, required %h", {fetch_valid, data_valid, bus_err, data_rdata}, {~e.tag, e.tag, e.err, e.val});
      end
      exp_rdata_hold = e.val;
    end
    wait_idle(ok);
    $display("store/load: addr 0020 read back %h", data_rdata);
  endtask

  task automatic test_arbitration();
    bit ok; int lat, sc, ab, both, early; logic [15:0] bs; exp_t e;
    mem[8'h1E] = 16'h1234; mem[8'h08] = 16'h7A11;
    fetch_req = 1'b1; fetch_addr = 16'h0008;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h001E;
    #1;
    vec_cnt++;
    if ({data_ready, fetch_ready} !== 2'b10) begin miss_cnt++; $display("FAIL arb_ready: got %b, required 10", {data_ready, fetch_ready}); end
    e.tag = 1'b1; e.store = 1'b0; e.err = 1'b0; e.val = 16'h1234; exp_q.push_back(e);
    @(posedge clk); @(negedge clk);
    data_req = 1'b0; data_addr = 16'hDEAD;
    wait_valid(40, 16'h001E, ok, lat, sc, ab, both, bs);
    vec_cnt++;
    if (!ok || exp_q.size() == 0) begin miss_cnt++; $display("FAIL arb_data_resp: no response, required one"); end
    else begin
      e = exp_q.pop_front();
      if ({fetch_valid, data_valid, bus_err, data_rdata} !== {~e.tag, e.tag, e.err, e.val}) begin
        miss_cnt++;
        $display("FAIL arb_data_resp: got %h, required %h", {fetch_valid, data_valid, bus_err, data_rdata}, {~e.tag, e.tag, e.err, e.val});
      end
      exp_rdata_hold = e.val;
    end
    ok = 1'b0; early = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (busy && fetch_ready) early++;
      if (!busy) ok = 1'b1;
    end
    vec_cnt++;
    if (!ok || fetch_ready !== 1'b1 || early != 0) begin
      miss_cnt++; $display("FAIL arb_fetch_ready: got ready=%b early=%0d, required 1 0", fetch_ready, early);
    end
    e.tag = 1'b0; e.store = 1'b0; e.err = 1'b0; e.val = 16'h7A11; exp_q.push_back(e);
    @(posedge clk); @(negedge clk);
    fetch_req = 1'b0; fetch_addr = 16'hDEAD;
    wait_valid(40, 16'h0008, ok, lat, sc, ab, both, bs);
    vec_cnt++;
    if (!ok || exp_q.size() == 0) begin miss_cnt++; $display("FAIL arb_fetch_resp: no response, required one"); end
    else begin
      e = exp_q.pop_front();
      if ({fetch_valid, data_valid, bus_err, fetch_data} !== {~e.tag, e.tag, e.err, e.val}) begin
        miss_cnt++;
        $display("FAIL arb_fetch_resp: got %h, required %h", {fetch_valid, data_valid, bus_err, fetch_data}, {~e.tag, e.tag, e.err, e.val});
      end
    end
    wait_idle(ok);
    $display("arbitration: load 001e=%h then fetch 0008=%h", data_rdata, fetch_data);
  endtask

  task automatic test_timeout();
    bit ok; int lat, sc, ab, both; logic [15:0] bs; exp_t e;
    mem_dead = 1'b1;
    issue(1'b1, 1'b0, 16'h0030, 16'h0, 16'h0000, 1'b1, ok);
    wait_valid(60, 16'h0030, ok, lat, sc, ab, both, bs);
    vec_cnt++;
    if (!ok || exp_q.size() == 0) begin miss_cnt++; $display("FAIL timeout_resp: no response, required one"); end
    else begin
      e = exp_q.pop_front();
      if ({fetch_valid, data_valid, bus_err, data_rdata} !== {~e.tag, e.tag, e.err, e.val}) begin
        miss_cnt++;
        $display("FAIL timeout_resp: got %h, required %h", {fetch_valid, data_valid, bus_err, data_rdata}, {~e.tag, e.tag, e.err, e.val});
      end
      exp_rdata_hold = e.val;
    end
    vec_cnt++;
    if (sc != 15) begin miss_cnt++; $display("FAIL timeout_len: got %0d strobe clocks, required 15", sc); end
    mem_dead = 1'b0;
    wait_idle(ok);
    vec_cnt++;
    if (!ok) begin miss_cnt++; $display("FAIL timeout_idle: got busy=1, required 0"); end
    $display("timeout: strobe held %0d clocks, bus_err response", sc);
  endtask

  task automatic test_slow_release();
    bit ok; int lat, sc, ab, both, waited, extra; logic [15:0] bs; exp_t e;
    hold_extra = 3; mem[8'h10] = 16'hBEEF;
    issue(1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, ok);
    wait_valid(40, 16'h0010, ok, lat, sc, ab, both, bs);
    vec_cnt++;
    if (!ok || exp_q.size() == 0) begin miss_cnt++; $display("FAIL slow_resp: no response, required one"); end
    else begin
      e = exp_q.pop_front();
      if ({fetch_valid, data_valid, bus_err, fetch_data} !== {~e.tag, e.tag, e.err, e.val}) begin
        miss_cnt++;
        $display("FAIL slow_resp: got %h, required %h", {fetch_valid, data_valid, bus_err, fetch_data}, {~e.tag, e.tag, e.err, e.val});
      end
    end
    fetch_req = 1'b1; fetch_addr = 16'h0004;
    ok = 1'b0; waited = 0; extra = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (fetch_valid || data_valid) extra++;
      if (fetch_ready) ok = 1'b1; else waited++;
    end
    vec_cnt++;
    if (!ok || waited != 3 || extra != 0) begin
      miss_cnt++; $display("FAIL slow_hold: got waited=%0d extra=%0d, required 3 0", waited, extra);
    end
    e.tag = 1'b0; e.store = 1'b0; e.err = 1'b0; e.val = 16'hF300; exp_q.push_back(e);
    @(posedge clk); @(negedge clk);
    fetch_req = 1'b0; fetch_addr = 16'hDEAD; hold_extra = 0;
    wait_valid(40, 16'h0004, ok, lat, sc, ab, both, bs);
    vec_cnt++;
    if (!ok || exp_q.size() == 0) begin miss_cnt++; $display("FAIL slow_next_resp: no response, required one"); end
    else begin
      e = exp_q.pop_front();
      if ({fetch_valid, data_valid, bus_err, fetch_data} !== {~e.tag, e.tag, e.err, e.val}) begin
        miss_cnt++;
        $display("FAIL slow_next_resp: got %h, required %h", {fetch_valid, data_valid, bus_err, fetch_data}, {~e.tag, e.tag, e.err, e.val});
      end
    end
    wait_idle(ok);
    $display("slow release: pending fetch held off %0d clocks", waited);
  endtask

  task automatic test_spurious_ack();
    int bad;
    bad = 0;
    spur_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if ({busy, readM, writeM, fetch_valid, data_valid} !== 5'b0) bad++;
    end
    spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (bad != 0 || busy !== 1'b0) begin miss_cnt++; $display("FAIL spurious_ack: got %0d bad cycles busy=%b, required 0 0", bad, busy); end
    $display("spurious ack: ignored in idle");
  endtask

  task automatic test_back_to_back();
    bit ok; int lat, sc, ab, both; logic [15:0] bs, a, v; exp_t e;
    for (int i = 0; i < 4; i++) begin
      a = 16'h0040 + 16'(i);
      v = 16'h1000 + 16'(i) * 16'h0111;
      mem[a[7:0]] = v;
    end
    for (int i = 0; i < 4; i++) begin
      a = 16'h0040 + 16'(i);
      v = 16'h1000 + 16'(i) * 16'h0111;
      issue(i[0], 1'b0, a, 16'h0, v, 1'b0, ok);
      wait_valid(40, a, ok, lat, sc, ab, both, bs);
      vec_cnt++;
      if (!ok || exp_q.size() == 0) begin miss_cnt++; $display("FAIL b2b_resp%0d: no response, required one", i); end
      else begin
        e = exp_q.pop_front();
        if ({fetch_valid, data_valid, bus_err, (e.tag ? data_rdata : fetch_data), ab[3:0]} !==
            {~e.tag, e.tag, e.err, e.val, 4'h0}) begin
          miss_cnt++;
          $display("FAIL b2b_resp%0d: got %h, required %h", i,
                   {fetch_valid, data_valid, bus_err, (e.tag ? data_rdata : fetch_data), ab[3:0]}, {~e.tag, e.tag, e.err, e.val, 4'h0});
        end
        if (e.tag) exp_rdata_hold = e.val;
      end
      $display("back-to-back %0d: addr %h tag %0d value %h", i, a, i[0], v);
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_read();
    bit ok; int extra;
    rd_lat = 6;
    issue(1'b0, 1'b0, 16'h0004, 16'h0, 16'hF300, 1'b0, ok);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({readM, fetch_valid, busy, address} !== 19'h0) begin
      miss_cnt++; $display("FAIL mid_reset: got %h, required 0", {readM, fetch_valid, busy, address});
    end
    tb_oe = 1'b1; tb_drv = 16'h3C5A; #1;
    vec_cnt++;
    if (data !== 16'h3C5A) begin miss_cnt++; $display("FAIL mid_reset_bus: got %h, required 3c5a", data); end
    tb_oe = 1'b0;
    reset_n = 1'b1;
    exp_q.delete();
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (fetch_valid || data_valid || busy) extra++;
    end
    vec_cnt++;
    if (extra != 0) begin miss_cnt++; $display("FAIL mid_reset_quiet: got %0d active cycles, required 0", extra); end
    rd_lat = 1;
    $display("reset mid-read: transfer aborted");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_fetch();
    test_store_load();
    test_arbitration();
    test_timeout();
    test_slow_release();
    test_spurious_ack();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
